// File: rtl/skid_register_slice.sv
// skid_register_slice
//   Valid/ready pipeline stage with both the forward (data/valid) and the
//   backward (ready) paths registered. There is no combinational path from
//   any input to any output. A main register feeds the output. A skid
//   register catches the one word that arrives in the cycle the downstream
//   stalls. Sustains one word per cycle with one cycle of latency.
//
//   Ports
//     clk, rst         clock; synchronous active-high reset
//     data_in_*        upstream payload / valid, data_in_ready (registered)
//     data_out_*       registered payload / valid, data_out_ready from downstream
//     occupancy        entries held (0, 1 or 2)
module skid_register_slice #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in_data,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out_data,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [1:0]            occupancy
);

  // The encoding equals the number of entries held, so occupancy is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;

  logic in_fire, out_fire;

  assign in_fire  = data_in_valid & ready_q;
  assign out_fire = valid_q & data_out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = data_in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = data_in_data;
        end else if (in_fire) begin
          // Downstream stalled. Park the new word behind the one on the output.
          skid_d  = data_in_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready_q is low here, so only a drain can happen.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Handshake flags are registered copies of the next state's decode.
    // Neither output is therefore driven combinationally from an input.
    ready_d = (state_d != FULL);
    valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign data_in_ready  = ready_q;
  assign data_out_valid = valid_q;
  assign data_out_data  = main_q;
  assign occupancy      = state_q;

endmodule

// File: tb/tb_skid_register_slice.sv
// Self-checking bench for skid_register_slice.
// The reference model is a FIFO queue of accepted words, with a capacity of
// two. Ready means fewer than two words are held. Valid means at least one
// word is held. The output shows the head word. When empty, it shows the last
// word that left, or zero after reset.
module tb_skid_register_slice;
  localparam int DW = 32;
  localparam logic [DW-1:0] GARBAGE = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in_data;
  logic          data_in_valid;
  logic          data_in_ready;
  logic [DW-1:0] data_out_data;
  logic          data_out_valid;
  logic          data_out_ready;
  logic [1:0]    occupancy;

  skid_register_slice #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in_data  (data_in_data),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out_data (data_out_data),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] hold;
  int            accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model. The bench is at a negedge here.
  task automatic check_model();
    chk("ready", 32'(data_in_ready),  32'(mq.size() < 2));
    chk("valid", 32'(data_out_valid), 32'(mq.size() > 0));
    chk("occ",   32'(occupancy),      32'(mq.size()));
    chk("data",  data_out_data,       (mq.size() > 0) ? mq[0] : hold);
    chk("garbage", 32'(data_out_data == GARBAGE), 32'd0);
  endtask

  // Apply inputs for one cycle starting from a negedge. Advance the model at
  // the posedge, then check the outputs at the next negedge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    bit in_fire, out_fire;
    data_in_valid  = v;
    data_in_data   = d;
    data_out_ready = r;
    in_fire  = v && (mq.size() < 2);
    out_fire = r && (mq.size() > 0);
    @(posedge clk);
    if (out_fire) hold = mq.pop_front();
    if (in_fire) begin
      mq.push_back(d);
      accepted++;
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset(input logic v, input logic [DW-1:0] d, input logic r);
    rst = 1'b1;
    data_in_valid  = v;
    data_in_data   = d;
    data_out_ready = r;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mq.delete();
    hold = '0;
    chk("rst_ready", 32'(data_in_ready),  32'd1);
    chk("rst_valid", 32'(data_out_valid), 32'd0);
    chk("rst_data",  data_out_data,       32'd0);
    chk("rst_occ",   32'(occupancy),      32'd0);
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    w = $urandom;
    if (w == GARBAGE) w = 32'h1234_5678;
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    data_in_valid = 1'b0;
    data_in_data = '0;
    data_out_ready = 1'b0;
    hold = '0;
    accepted = 0;
    @(negedge clk);

    // Reset, with active inputs that must be ignored.
    do_reset(1'b1, 32'h55, 1'b1);

    // Streaming: words 1..16 go through back-to-back.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 32'(i), 1'b1);
      chk("stream_ready", 32'(data_in_ready), 32'd1);
      chk("stream_out", data_out_data, 32'(i));
    end
    step(1'b0, GARBAGE, 1'b1);
    chk("stream_drained", 32'(data_out_valid), 32'd0);

    // Skid: 0xA on the output, then the downstream stalls while 0xB arrives.
    do_reset(1'b0, GARBAGE, 1'b0);
    step(1'b1, 32'hA, 1'b1);
    step(1'b1, 32'hB, 1'b0);
    chk("skid_occ",   32'(occupancy),     32'd2);
    chk("skid_ready", 32'(data_in_ready), 32'd0);
    chk("skid_hold",  data_out_data,      32'hA);
    step(1'b1, 32'hC, 1'b0);
    chk("skid_hold2", data_out_data, 32'hA);
    step(1'b0, GARBAGE, 1'b1);
    chk("skid_b", data_out_data, 32'hB);
    chk("skid_reready", 32'(data_in_ready), 32'd1);
    step(1'b0, GARBAGE, 1'b1);

    // Reset while full: 0x5 and 0x6 are discarded and never emitted.
    step(1'b1, 32'h5, 1'b0);
    step(1'b1, 32'h6, 1'b0);
    chk("full_occ", 32'(occupancy), 32'd2);
    do_reset(1'b1, 32'h7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, GARBAGE, 1'b1);
      chk("no_5", 32'(data_out_valid && data_out_data == 32'h5), 32'd0);
      chk("no_6", 32'(data_out_valid && data_out_data == 32'h6), 32'd0);
    end

    // Random valid/ready at 50%/50%. Garbage rides the bus while valid is low.
    accepted = 0;
    begin
      int cyc = 0;
      while (accepted < 10000 && cyc < 60000) begin
        logic v, r;
        v = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        step(v, v ? rnd_word() : GARBAGE, r);
        cyc++;
      end
      chk("rand_budget", 32'(accepted >= 10000), 32'd1);
      for (int i = 0; i < 4; i++) step(1'b0, GARBAGE, 1'b1);
      chk("rand_drained", 32'(mq.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
